ball_renderer: RTL and testbench

Consumer side of the moving-object position/colour interface. It takes the object's top-left position and colour, snapshots them once per frame, and answers per-pixel raster queries with the pixel colour: sprite colour, outline or background. It sits between the object logic and the display scan-out on the 256x128, 12-bit-colour screen. It also reports how many sprite pixels were drawn in the previous frame.

---
 rtl/gfx_pkg.sv | 11 +
 rtl/ball_renderer_span_hit.sv | 23 ++
 rtl/ball_renderer.sv | 119 +++++++++++
 tb/tb_ball_renderer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared screen geometry and pixel types for the display pipeline.
package gfx_pkg;

   localparam int unsigned SCREEN_W = 256;
   localparam int unsigned SCREEN_H = 128;

   typedef logic [$clog2(SCREEN_W)-1:0] x_t;
   typedef logic [$clog2(SCREEN_H)-1:0] y_t;
   typedef logic [11:0]                 color_t;

endpackage

// File: rtl/ball_renderer_span_hit.sv
// One-dimensional sprite coverage test: start <= pos < start+SIZE, no wrap-around.
module span_hit #(
   parameter int unsigned W    = 8,
   parameter int unsigned SIZE = 8
) (
   input  logic [W-1:0] pos,
   input  logic [W-1:0] start,
   output logic         in_span,
   output logic         on_edge
);

   // One extra bit keeps start+SIZE from wrapping past the screen edge.
   logic [W:0] pos_e, start_e, end_e, last_e;

   assign pos_e   = {1'b0, pos};
   assign start_e = {1'b0, start};
   assign end_e   = start_e + (W+1)'(SIZE);
   assign last_e  = end_e - (W+1)'(1);

   assign in_span = (pos_e >= start_e) && (pos_e < end_e);
   assign on_edge = (pos_e == start_e) || (pos_e == last_e);

endmodule

// File: rtl/ball_renderer.sv
// Per-pixel sprite renderer: snapshots object position/colour each frame and
// answers raster queries with a fixed two-cycle latency; counts drawn pixels.
module ball_renderer
   import gfx_pkg::*;
#(
   parameter int unsigned SIZE          = 8,
   parameter color_t      BG_COLOR      = 12'h000,
   parameter bit          OUTLINE_EN    = 1'b0,
   parameter color_t      OUTLINE_COLOR = 12'hFFF
) (
   input  logic         clk,
   input  logic         rst,
   input  x_t           obj_x,
   input  y_t           obj_y,
   input  color_t       obj_color,
   input  logic         frame_start,
   input  logic         px_valid,
   input  x_t           px_x,
   input  y_t           px_y,
   output logic         out_valid,
   output color_t       out_color,
   output logic         out_hit,
   output logic [15:0]  hit_count
);

   x_t          shadow_x;
   y_t          shadow_y;
   color_t      shadow_color;
   logic        armed;
   logic [15:0] acc;

   logic        valid1, hit1, edge1;
   color_t      color1;

   // A query in the same cycle as frame_start sees the incoming object values.
   x_t     sx;
   y_t     sy;
   color_t sc;
   logic   armed_eff;

   assign sx        = frame_start ? obj_x     : shadow_x;
   assign sy        = frame_start ? obj_y     : shadow_y;
   assign sc        = frame_start ? obj_color : shadow_color;
   assign armed_eff = armed | frame_start;

   logic hx, hy, ex, ey, hit_c, edge_c;

   span_hit #(.W($bits(x_t)), .SIZE(SIZE)) u_span_x (
      .pos     (px_x),
      .start   (sx),
      .in_span (hx),
      .on_edge (ex)
   );

   span_hit #(.W($bits(y_t)), .SIZE(SIZE)) u_span_y (
      .pos     (px_y),
      .start   (sy),
      .in_span (hy),
      .on_edge (ey)
   );

   assign hit_c  = hx & hy & armed_eff;
   assign edge_c = hit_c & (ex | ey);

   logic inc;
   assign inc = out_valid & out_hit;

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_x     <= '0;
         shadow_y     <= '0;
         shadow_color <= '0;
         armed        <= 1'b0;
         valid1       <= 1'b0;
         hit1         <= 1'b0;
         edge1        <= 1'b0;
         color1       <= '0;
         out_valid    <= 1'b0;
         out_hit      <= 1'b0;
         out_color    <= '0;
         acc          <= '0;
         hit_count    <= '0;
      end else begin
         if (frame_start) begin
            shadow_x     <= obj_x;
            shadow_y     <= obj_y;
            shadow_color <= obj_color;
            armed        <= 1'b1;
         end

         valid1 <= px_valid;
         hit1   <= hit_c;
         edge1  <= edge_c;
         color1 <= sc;

         out_valid <= valid1;
         out_hit   <= valid1 & hit1;
         if (valid1) begin
            if (!hit1)
               out_color <= BG_COLOR;
            else if (OUTLINE_EN && edge1)
               out_color <= OUTLINE_COLOR;
            else
               out_color <= color1;
         end

         // A result leaving the pipe on the frame_start cycle closes the old frame.
         if (frame_start) begin
            hit_count <= acc + 16'(inc);
            acc       <= '0;
         end else begin
            acc <= acc + 16'(inc);
         end
      end
   end

endmodule

// File: tb/tb_ball_renderer.sv
// Self-checking bench for ball_renderer: table vectors, raster scan and
// corner sequences, all checked through an expected-result queue.
module tb_ball_renderer;
   import gfx_pkg::*;

   localparam int unsigned SZ  = 8;
   localparam color_t      BG0 = 12'h000;
   localparam color_t      BG1 = 12'h00A;
   localparam color_t      OL1 = 12'hFFF;

   logic        clk = 1'b0;
   logic        rst;
   x_t          obj_x;
   y_t          obj_y;
   color_t      obj_color;
   logic        frame_start;
   logic        px_valid;
   x_t          px_x;
   y_t          px_y;

   logic        out_valid, out_hit;
   color_t      out_color;
   logic [15:0] hit_count;
   logic        ol_valid, ol_hit;
   color_t      ol_color;
   logic [15:0] ol_count;

   always #5 clk = ~clk;

   ball_renderer #(.SIZE(SZ)) dut (
      .clk         (clk),
      .rst         (rst),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
      .obj_color   (obj_color),
      .frame_start (frame_start),
      .px_valid    (px_valid),
      .px_x        (px_x),
      .px_y        (px_y),
      .out_valid   (out_valid),
      .out_color   (out_color),
      .out_hit     (out_hit),
      .hit_count   (hit_count)
   );

   ball_renderer #(.SIZE(SZ), .BG_COLOR(BG1), .OUTLINE_EN(1'b1), .OUTLINE_COLOR(OL1)) dut_ol (
      .clk         (clk),
      .rst         (rst),
      .obj_x       (obj_x),
      .obj_y       (obj_y),
      .obj_color   (obj_color),
      .frame_start (frame_start),
      .px_valid    (px_valid),
      .px_x        (px_x),
      .px_y        (px_y),
      .out_valid   (ol_valid),
      .out_color   (ol_color),
      .out_hit     (ol_hit),
      .hit_count   (ol_count)
   );

   typedef struct packed {
      logic   hit;
      color_t c0;
      color_t c1;
   } exp_t;

   typedef struct {
      x_t   x;
      y_t   y;
      logic hit;
      logic brd;
   } vec_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: snapshot, arming, two-stage valid delay and counter.
   color_t      m_col;
   logic        m_armed;
   logic        d1, d2, pending;
   logic [15:0] m_acc, m_hc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic in_box(input int x, input int y, input int sx, input int sy);
      return (x >= sx) && (x < sx + int'(SZ)) && (y >= sy) && (y < sy + int'(SZ));
   endfunction

   function automatic logic on_border(input int x, input int y, input int sx, input int sy);
      return in_box(x, y, sx, sy) &&
             (x == sx || x == sx + int'(SZ) - 1 || y == sy || y == sy + int'(SZ) - 1);
   endfunction

   task automatic model_flush();
      exp_q.delete();
      d1 = 1'b0; d2 = 1'b0; pending = 1'b0;
      m_acc = '0; m_hc = '0;
      m_col = '0; m_armed = 1'b0;
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      if (!rst) begin
         if (frame_start) begin
            m_hc    = m_acc + 16'(pending);
            m_acc   = '0;
            m_col   = obj_color;
            m_armed = 1'b1;
         end else begin
            m_acc = m_acc + 16'(pending);
         end
         d2 = d1;
         d1 = px_valid;
      end
      #1;
      check("out_valid latency", 32'(out_valid), 32'(d2));
      pending = 1'b0;
      if (d2) begin
         if (exp_q.size() == 0) begin
            check("scoreboard underflow", 32'(1), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("out_hit", 32'(out_hit), 32'(e.hit));
            check("out_color", 32'(out_color), 32'(e.c0));
            check("outline out_hit", 32'(ol_hit), 32'(e.hit));
            check("outline out_color", 32'(ol_color), 32'(e.c1));
            pending = e.hit;
         end
      end
      check("hit_count", 32'(hit_count), 32'(m_hc));
      frame_start = 1'b0;
      px_valid    = 1'b0;
   endtask

   // Presents one cycle of stimulus; eh/eb are the expected hit/border flags.
   task automatic drive(input logic fs, input logic pv, input x_t x, input y_t y,
                        input logic eh, input logic eb);
      exp_t   e;
      color_t col;
      frame_start = fs;
      px_valid    = pv;
      px_x        = x;
      px_y        = y;
      col = fs ? obj_color : m_col;
      if (pv) begin
         e.hit = eh;
         e.c0  = eh ? col : BG0;
         e.c1  = !eh ? BG1 : (eb ? OL1 : col);
         exp_q.push_back(e);
      end
      tick();
   endtask

   task automatic set_obj(input x_t x, input y_t y, input color_t c);
      obj_x = x; obj_y = y; obj_color = c;
   endtask

   vec_t basic_tab[5];
   vec_t clip_tab[4];

   initial begin
      basic_tab[0] = '{x: 8'd10, y: 7'd20, hit: 1'b1, brd: 1'b1};
      basic_tab[1] = '{x: 8'd17, y: 7'd27, hit: 1'b1, brd: 1'b1};
      basic_tab[2] = '{x: 8'd18, y: 7'd20, hit: 1'b0, brd: 1'b0};
      basic_tab[3] = '{x: 8'd10, y: 7'd28, hit: 1'b0, brd: 1'b0};
      basic_tab[4] = '{x: 8'd11, y: 7'd21, hit: 1'b1, brd: 1'b0};

      clip_tab[0] = '{x: 8'd255, y: 7'd127, hit: 1'b1, brd: 1'b1};
      clip_tab[1] = '{x: 8'd0,   y: 7'd120, hit: 1'b0, brd: 1'b0};
      clip_tab[2] = '{x: 8'd255, y: 7'd0,   hit: 1'b0, brd: 1'b0};
      clip_tab[3] = '{x: 8'd253, y: 7'd123, hit: 1'b1, brd: 1'b0};

      rst = 1'b1;
      frame_start = 1'b0;
      px_valid = 1'b0;
      px_x = '0;
      px_y = '0;
      set_obj('0, '0, '0);
      model_flush();

      tick();
      tick();
      check("reset out_valid", 32'(out_valid), 32'(0));
      check("reset out_hit", 32'(out_hit), 32'(0));
      check("reset out_color", 32'(out_color), 32'(0));
      check("reset hit_count", 32'(hit_count), 32'(0));
      check("reset outline out_color", 32'(ol_color), 32'(0));
      rst = 1'b0;
      tick();

      // Unarmed: no frame_start yet, query on top of the object still misses.
      set_obj(8'd0, 7'd0, 12'hABC);
      drive(1'b0, 1'b1, 8'd0, 7'd0, 1'b0, 1'b0);
      tick();
      tick();

      // Snapshot, then disturb obj_*: queries must still use the snapshot.
      set_obj(8'd10, 7'd20, 12'hF0F);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      set_obj(8'd100, 7'd100, 12'h0F0);
      for (int i = 0; i < 5; i++)
         drive(1'b0, 1'b1, basic_tab[i].x, basic_tab[i].y, basic_tab[i].hit, basic_tab[i].brd);
      tick();
      tick();

      // Clipping at the right/bottom screen edges.
      set_obj(8'd252, 7'd120, 12'h3C5);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         drive(1'b0, 1'b1, clip_tab[i].x, clip_tab[i].y, clip_tab[i].hit, clip_tab[i].brd);
      tick();
      tick();

      // Same-cycle frame_start and query take the bypass path.
      set_obj(8'd50, 7'd50, 12'h777);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      set_obj(8'd0, 7'd0, 12'h123);
      drive(1'b1, 1'b1, 8'd0, 7'd0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 8'd50, 7'd50, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 8'd7, 7'd7, 1'b1, 1'b1);
      tick();
      tick();

      // Full raster scan, drain, then close the frame.
      set_obj(8'd10, 7'd20, 12'h5A5);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      for (int y = 0; y < int'(SCREEN_H); y++)
         for (int x = 0; x < int'(SCREEN_W); x++)
            drive(1'b0, 1'b1, x_t'(x), y_t'(y), in_box(x, y, 10, 20), on_border(x, y, 10, 20));
      tick();
      tick();
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      check("frame hit_count", 32'(hit_count), 32'd64);
      check("outline frame hit_count", 32'(ol_count), 32'd64);

      // Reset while a query sits in stage 1: it must never emerge.
      drive(1'b0, 1'b1, 8'd12, 7'd22, 1'b1, 1'b0);
      rst = 1'b1;
      model_flush();
      #1;
      check("async reset hit_count", 32'(hit_count), 32'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("post-reset out_valid", 32'(out_valid), 32'(0));
      check("post-reset hit_count", 32'(hit_count), 32'(0));
      check("post-reset queue empty", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
